// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter: valid/ready word load, one bit per shift_en tick.
// Optional macro PIS_SHIFT_TX_PARITY_EN appends an even-parity bit after the data bits.
module piso_shift_tx #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic                         Clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         load_valid,
  output logic                         load_ready,
  input  logic                         shift_en,
  output logic                         sout,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(WIDTH+1)-1:0]   bit_cnt
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

`ifdef PIS_SHIFT_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_e;
`endif

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic               sout_q, sout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
`ifdef PIS_SHIFT_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  logic               accept;
  logic               last_bit;
  logic               first_bit;
  logic [WIDTH-1:0]   sreg_shift;
  logic               next_bit;

  assign load_ready = (state_q == IDLE) && !reset;
  assign accept     = load_valid && load_ready;
  assign last_bit   = (bit_cnt_q == CNT_W'(WIDTH - 1));
  assign first_bit  = MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
  // The bit to be sent next always sits at the outgoing end of the register.
  assign sreg_shift = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
  assign next_bit   = MSB_FIRST ? sreg_shift[WIDTH-1] : sreg_shift[0];

  // State register
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = SHIFT;
`ifdef PIS_SHIFT_TX_PARITY_EN
      SHIFT: if (shift_en && last_bit) state_d = PAR;
      PAR:   if (shift_en) state_d = IDLE;
`else
      SHIFT: if (shift_en && last_bit) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    sreg_d    = sreg_q;
    sout_d    = sout_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bit_cnt_d = bit_cnt_q;
`ifdef PIS_SHIFT_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          sreg_d    = data_in;
          sout_d    = first_bit;
          busy_d    = 1'b1;
          bit_cnt_d = '0;
`ifdef PIS_SHIFT_TX_PARITY_EN
          parity_d  = ^data_in;
`endif
        end
      end
      SHIFT: begin
        if (shift_en) begin
          if (!last_bit) begin
            sreg_d    = sreg_shift;
            sout_d    = next_bit;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end else begin
`ifdef PIS_SHIFT_TX_PARITY_EN
            sout_d    = parity_q;
            bit_cnt_d = CNT_W'(WIDTH);
`else
            sout_d    = IDLE_LEVEL;
            busy_d    = 1'b0;
            bit_cnt_d = '0;
            done_d    = 1'b1;
`endif
          end
        end
      end
`ifdef PIS_SHIFT_TX_PARITY_EN
      PAR: begin
        if (shift_en) begin
          sout_d    = IDLE_LEVEL;
          busy_d    = 1'b0;
          bit_cnt_d = '0;
          done_d    = 1'b1;
        end
      end
`endif
      default: begin
        sout_d    = IDLE_LEVEL;
        busy_d    = 1'b0;
        bit_cnt_d = '0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge Clk) begin
    if (reset) begin
      sreg_q    <= '0;
      sout_q    <= IDLE_LEVEL;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bit_cnt_q <= '0;
`ifdef PIS_SHIFT_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      sreg_q    <= sreg_d;
      sout_q    <= sout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bit_cnt_q <= bit_cnt_d;
`ifdef PIS_SHIFT_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign sout    = sout_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign bit_cnt = bit_cnt_q;

endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed vector bench for piso_shift_tx: MSB-first and LSB-first instances share stimulus.
// Follows PIS_SHIFT_TX_PARITY_EN when defined (parity bit inserted into the expected stream).
module tb_piso_shift_tx;

  typedef struct {
    logic       rst;
    logic       lv;
    logic       se;
    logic [7:0] din;
    logic       s_msb;
    logic       s_lsb;
    logic       busy;
    logic       done;
    logic       ready;
    logic [3:0] cnt;
  } vec_t;

  logic       Clk;
  logic       reset;
  logic [7:0] data_in;
  logic       load_valid;
  logic       shift_en;

  logic       ready_m, sout_m, busy_m, done_m;
  logic [3:0] cnt_m;
  logic       ready_l, sout_l, busy_l, done_l;
  logic [3:0] cnt_l;

  vec_t vq[$];
  int   n_vec;
  int   n_bad;

  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
    .Clk(Clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(ready_m), .shift_en(shift_en), .sout(sout_m), .busy(busy_m),
    .done(done_m), .bit_cnt(cnt_m)
  );

  piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
    .Clk(Clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(ready_l), .shift_en(shift_en), .sout(sout_l), .busy(busy_l),
    .done(done_l), .bit_cnt(cnt_l)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic void add(input logic rst, input logic lv, input logic se,
                              input logic [7:0] din, input logic sm, input logic sl,
                              input logic bsy, input logic dn, input logic rdy,
                              input logic [3:0] cnt);
    vec_t v;
    v.rst = rst; v.lv = lv; v.se = se; v.din = din;
    v.s_msb = sm; v.s_lsb = sl; v.busy = bsy; v.done = dn; v.ready = rdy; v.cnt = cnt;
    vq.push_back(v);
  endfunction

  // sm/sl list the expected serial stream, first-sent bit in position 7.
  function automatic void add_word(input logic [7:0] din, input logic [7:0] dother,
                                   input logic hold, input int period,
                                   input logic [7:0] sm, input logic [7:0] sl,
                                   input logic par);
    add(1'b0, 1'b1, 1'b1, din, sm[7], sl[7], 1'b1, 1'b0, 1'b0, 4'd0);
    for (int k = 0; k < 8; k++) begin
      for (int h = 1; h < period; h++)
        add(1'b0, hold, 1'b0, dother, sm[7-k], sl[7-k], 1'b1, 1'b0, 1'b0, 4'(k));
      if (k < 7)
        add(1'b0, hold, 1'b1, dother, sm[6-k], sl[6-k], 1'b1, 1'b0, 1'b0, 4'(k + 1));
    end
`ifdef PIS_SHIFT_TX_PARITY_EN
    add(1'b0, hold, 1'b1, dother, par, par, 1'b1, 1'b0, 1'b0, 4'd8);
    for (int h = 1; h < period; h++)
      add(1'b0, hold, 1'b0, dother, par, par, 1'b1, 1'b0, 1'b0, 4'd8);
`else
    if (par === 1'bx) add(1'b0, hold, 1'b0, dother, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
`endif
    add(1'b0, hold, 1'b1, dother, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
  endfunction

  task automatic chk(input int idx, input string nm, input logic [3:0] got, input logic [3:0] exp);
    if (got !== exp) begin
      n_bad++;
      $display("FAIL vec %0d %s: got %0h expected %0h", idx, nm, got, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1; load_valid = 1'b0; shift_en = 1'b0; data_in = 8'h00;

    // 1: reset, then 0xA5 continuous ticks; trailing idle tick is ignored
    add(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    add(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    add_word(8'hA5, 8'hA5, 1'b0, 1, 8'b10100101, 8'b10100101, 1'b0);
    add(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    // 2: 0x01 (single set bit exposes ordering)
    add_word(8'h01, 8'h01, 1'b0, 1, 8'b00000001, 8'b10000000, 1'b1);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    // 3: 0xF0 with one tick every four cycles
    add_word(8'hF0, 8'hF0, 1'b0, 4, 8'b11110000, 8'b00001111, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    // 4: reset after three bits of 0xFF, then 0x81
    add(1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    add(1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
    add(1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2);
    add(1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3);
    add(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    add(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    add_word(8'h81, 8'h81, 1'b0, 1, 8'b10000001, 8'b10000001, 1'b0);
    // 5: load_valid held, data_in moves to the next word mid-transfer, back-to-back
    add_word(8'h3C, 8'hC3, 1'b1, 1, 8'b00111100, 8'b00111100, 1'b0);
    add_word(8'hC3, 8'h5A, 1'b0, 1, 8'b11000011, 8'b11000011, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
    // 6: odd and even parity words
    add_word(8'h07, 8'h07, 1'b0, 1, 8'b00000111, 8'b11100000, 1'b1);
    add_word(8'h03, 8'h03, 1'b0, 2, 8'b00000011, 8'b11000000, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);

    foreach (vq[i]) begin
      @(negedge Clk);
      reset      = vq[i].rst;
      load_valid = vq[i].lv;
      shift_en   = vq[i].se;
      data_in    = vq[i].din;
      @(posedge Clk);
      #1;
      n_vec++;
      chk(i, "sout_msb",  {3'b0, sout_m},  {3'b0, vq[i].s_msb});
      chk(i, "sout_lsb",  {3'b0, sout_l},  {3'b0, vq[i].s_lsb});
      chk(i, "busy_msb",  {3'b0, busy_m},  {3'b0, vq[i].busy});
      chk(i, "busy_lsb",  {3'b0, busy_l},  {3'b0, vq[i].busy});
      chk(i, "done_msb",  {3'b0, done_m},  {3'b0, vq[i].done});
      chk(i, "done_lsb",  {3'b0, done_l},  {3'b0, vq[i].done});
      chk(i, "ready_msb", {3'b0, ready_m}, {3'b0, vq[i].ready});
      chk(i, "ready_lsb", {3'b0, ready_l}, {3'b0, vq[i].ready});
      chk(i, "cnt_msb",   cnt_m,           vq[i].cnt);
      chk(i, "cnt_lsb",   cnt_l,           vq[i].cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
